// File: rtl/duck_rom_arbiter.sv
// duck_rom_arbiter: round-robin sharing of one duck sprite ROM among NUM_REQ renderers, tagging each read with its requester id.
// Build option DUCK_ARB_PRIO0_EN gives requester 0 fixed priority over the rotating others.
module duck_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("duck_rom_arbiter: NUM_REQ must be 2..8");
        end
        if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_rom_lat
            $error("duck_rom_arbiter: ROM_LAT must be 1..3");
        end
    endgenerate

`ifdef DUCK_ARB_PRIO0_EN
    localparam int WRAP = 1;
`else
    localparam int WRAP = 0;
`endif

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   nxt_ptr;
    logic              found;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [ADDR_W-1:0] sel_addr;
    int                idx;
    logic              pipe_v  [ROM_LAT];
    logic [ID_W-1:0]   pipe_id [ROM_LAT];

    // Walk offsets from the far end so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int o = NUM_REQ - 1; o >= 0; o--) begin
            idx = int'(rr_ptr) + o;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx] && idx >= WRAP) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
`ifdef DUCK_ARB_PRIO0_EN
        if (req[0]) begin
            found = 1'b1;
            win   = '0;
        end
        nxt_ptr = req[0] ? rr_ptr : (int'(win) == NUM_REQ - 1) ? ID_W'(WRAP) : win + 1'b1;
`else
        nxt_ptr = (int'(win) == NUM_REQ - 1) ? ID_W'(WRAP) : win + 1'b1;
`endif
        gnt_nxt  = found ? NUM_REQ'(1) << win : '0;
        sel_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt       <= '0;
            rom_addr  <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                pipe_v[s]  <= 1'b0;
                pipe_id[s] <= '0;
            end
        end else begin
            gnt <= gnt_nxt;
            if (found) begin
                rom_addr <= sel_addr;
                rr_ptr   <= nxt_ptr;
            end
            pipe_v[0]  <= found;
            pipe_id[0] <= win;
            for (int s = 1; s < ROM_LAT; s++) begin
                pipe_v[s]  <= pipe_v[s-1];
                pipe_id[s] <= pipe_id[s-1];
            end
            rsp_valid <= pipe_v[ROM_LAT-1];
            if (pipe_v[ROM_LAT-1]) begin
                rsp_id   <= pipe_id[ROM_LAT-1];
                rsp_data <= rom_q;
            end
        end
    end
endmodule

// File: tb/tb_duck_rom_arbiter.sv
// tb_duck_rom_arbiter: vector table plus corner sequences for duck_rom_arbiter, one DUT at ROM_LAT=1 and one at ROM_LAT=2.
module tb_duck_rom_arbiter;
    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [51:0] req_addr = {13'h040, 13'h030, 13'h020, 13'h010};
    logic [3:0]  gnt1, gnt2;
    logic [12:0] a1, a2, a2d;
    logic [3:0]  q1, q2;
    logic        v1, v2;
    logic [1:0]  id1, id2;
    logic [3:0]  d1, d2;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [12:0] addr;
        logic        v;
        logic [1:0]  id;
        logic [3:0]  data;
    } vec_t;
    vec_t tbl [17];

    always #5 vga_clk = ~vga_clk;

    duck_rom_arbiter #(.NUM_REQ(4), .ADDR_W(13), .DATA_W(4), .ROM_LAT(1)) u1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(gnt1),
        .rom_addr(a1), .rom_q(q1), .rsp_valid(v1), .rsp_id(id1), .rsp_data(d1));
    duck_rom_arbiter #(.NUM_REQ(4), .ADDR_W(13), .DATA_W(4), .ROM_LAT(2)) u2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(gnt2),
        .rom_addr(a2), .rom_q(q2), .rsp_valid(v2), .rsp_id(id2), .rsp_data(d2));

    function automatic logic [3:0] rom_f(logic [12:0] a);
        return (a[3:0] ^ a[7:4]) + 4'd3;
    endfunction

    // ROM read on the falling edge gives latency 1; an extra address register gives latency 2.
    always @(negedge vga_clk) q1 <= rom_f(a1);
    always @(posedge vga_clk) a2d <= a2;
    always @(negedge vga_clk) q2 <= rom_f(a2d);

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    logic [3:0] exp6 [7];
    logic [6:0] pv;

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001, 13'h010, 1'b0, 2'd0, 4'd0};
`ifdef DUCK_ARB_PRIO0_EN
        tbl[1]  = '{4'b1111, 4'b0001, 13'h010, 1'b1, 2'd0, 4'd4};
        tbl[2]  = '{4'b1111, 4'b0001, 13'h010, 1'b1, 2'd0, 4'd4};
        tbl[3]  = '{4'b1111, 4'b0001, 13'h010, 1'b1, 2'd0, 4'd4};
        tbl[4]  = '{4'b1111, 4'b0001, 13'h010, 1'b1, 2'd0, 4'd4};
        exp6 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
`else
        tbl[1]  = '{4'b1111, 4'b0010, 13'h020, 1'b1, 2'd0, 4'd4};
        tbl[2]  = '{4'b1111, 4'b0100, 13'h030, 1'b1, 2'd1, 4'd5};
        tbl[3]  = '{4'b1111, 4'b1000, 13'h040, 1'b1, 2'd2, 4'd6};
        tbl[4]  = '{4'b1111, 4'b0001, 13'h010, 1'b1, 2'd3, 4'd7};
        exp6 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
`endif
        tbl[5]  = '{4'b0100, 4'b0100, 13'h030, 1'b1, 2'd0, 4'd4};
        tbl[6]  = '{4'b0100, 4'b0100, 13'h030, 1'b1, 2'd2, 4'd6};
        tbl[7]  = '{4'b0100, 4'b0100, 13'h030, 1'b1, 2'd2, 4'd6};
        tbl[8]  = '{4'b0100, 4'b0100, 13'h030, 1'b1, 2'd2, 4'd6};
        tbl[9]  = '{4'b0100, 4'b0100, 13'h030, 1'b1, 2'd2, 4'd6};
        tbl[10] = '{4'b0000, 4'b0000, 13'h030, 1'b1, 2'd2, 4'd6};
        tbl[11] = '{4'b0000, 4'b0000, 13'h030, 1'b0, 2'd2, 4'd6};
        tbl[12] = '{4'b1000, 4'b1000, 13'h040, 1'b0, 2'd2, 4'd6};
        tbl[13] = '{4'b1010, 4'b0010, 13'h020, 1'b1, 2'd3, 4'd7};
        tbl[14] = '{4'b1000, 4'b1000, 13'h040, 1'b1, 2'd1, 4'd5};
        tbl[15] = '{4'b0000, 4'b0000, 13'h040, 1'b1, 2'd3, 4'd7};
        tbl[16] = '{4'b0000, 4'b0000, 13'h040, 1'b0, 2'd3, 4'd7};

        reset_n = 1'b0;
        req = 4'b1111;
        repeat (3) step();
        chk("reset_lat1", {gnt1, a1, v1, id1, d1}, 24'h0);
        chk("reset_lat2", {gnt2, a2, v2, id2, d2}, 24'h0);
        @(negedge vga_clk);
        reset_n = 1'b1;

        // The latency-2 DUT shows the latency-1 response fields one cycle later.
        pv = '0;
        for (int r = 0; r < 17; r++) begin
            req = tbl[r].req;
            step();
            chk($sformatf("vec%0d_lat1", r), {gnt1, a1, v1, id1, d1},
                {tbl[r].gnt, tbl[r].addr, tbl[r].v, tbl[r].id, tbl[r].data});
            chk($sformatf("vec%0d_lat2", r), {gnt2, a2, v2, id2, d2},
                {tbl[r].gnt, tbl[r].addr, pv});
            pv = {tbl[r].v, tbl[r].id, tbl[r].data};
        end

        for (int c = 0; c < 7; c++) begin
            req = (c < 3) ? 4'b1111 : 4'b1110;
            step();
            chk($sformatf("prio_seq%0d_lat1", c), {20'h0, gnt1}, {20'h0, exp6[c]});
            chk($sformatf("prio_seq%0d_lat2", c), {20'h0, gnt2}, {20'h0, exp6[c]});
        end

        req = 4'b0010;
        step();
        chk("pre_reset_gnt", {20'h0, gnt2}, 24'h000002);
        req = 4'b0000;
        @(negedge vga_clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset_lat2", {gnt2, a2, v2, id2, d2}, 24'h0);
        chk("async_reset_lat1", {gnt1, a1, v1, id1, d1}, 24'h0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        step();
        chk("flushed_read_lat2", {gnt2, a2, v2, id2, d2}, 24'h0);
        step();
        chk("idle_after_reset_lat2", {gnt2, a2, v2, id2, d2}, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
